spu_issue_ctrl: RTL and testbench
=================================

Name: spu_issue_ctrl

Overview:
- Dual-issue dispatch stage between SPU decode and the even/odd execution pipes.
- Holds one decoded instruction pair and presents its source addresses to the register scoreboard.
- Issues each slot only when its operands are not busy and in-order rules allow it.
- Drives the scoreboard's destination inputs for every instruction it issues.

Parameters:
- ADDR_W, 7, register address width (128-entry register file).
- OPC_W, 11, opcode field width carried to the pipes.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of the held pair; no issue in that cycle.
- in_valid  in  1  decode presents a pair.
- in_ready  out  1  stage accepts the pair this cycle.
- in_even_vld / in_odd_vld  in  1  slot occupied in the presented pair.
- in_even_opc / in_odd_opc  in  OPC_W  opcodes.
- in_even_ra, in_even_rb, in_even_rt, in_odd_ra, in_odd_rb, in_odd_rt  in  ADDR_W  source and destination addresses.
- ra_even_addr, rb_even_addr, ra_odd_addr, rb_odd_addr  out  ADDR_W  held-pair sources to the scoreboard (combinational from hold registers).
- regstatus_1_a, regstatus_1_b, regstatus_2_a, regstatus_2_b  in  1  scoreboard busy bits for even ra/rb and odd ra/rb.
- dest_1 / dest_2  out  ADDR_W  rt of the even/odd instruction issuing this cycle, else 0 (combinational).
- even_issue_vld / odd_issue_vld  out  1  registered issue strobe to the pipes.
- even_opc_o, even_ra_o, even_rb_o, even_rt_o, odd_opc_o, odd_ra_o, odd_rb_o, odd_rt_o  out  various  registered issued instruction fields.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: all hold registers and pending bits cleared. All *_o, issue strobes, dest_1/dest_2 and stall_cycles are 0. in_ready is 1.
- State is the pending bits {ev_pend, od_pend}: EMPTY=00, BOTH=11, EVEN_ONLY=10, ODD_ONLY=01.
- Even issue (ev_go): ev_pend & ~regstatus_1_a & ~regstatus_1_b & ~flush.
- Odd issue (od_go): od_pend & ~regstatus_2_a & ~regstatus_2_b & ~flush, and in-order (~ev_pend | ev_go).
- Odd is also blocked when ev_go is set, even_rt != 0, and odd ra or rb equals even_rt (intra-pair RAW). Odd retries next cycle, when the scoreboard reports it busy.
- Address 0 is never treated as a dependency.
- dest_1 = ev_go ? even_rt : 0; dest_2 = od_go ? odd_rt : 0. Both are valid in the same cycle so the scoreboard marks them busy at that edge.
- Issue latency: strobe and fields appear the cycle after the go decision and stay 1 cycle. Strobe is 0 when no issue.
- Pending bit clears on its go. The held pair is drained when all pending bits are clear after this cycle's go signals.
- in_ready = drained | flush. It is combinational on the regstatus inputs.
- Load on in_valid & in_ready: ev_pend=in_even_vld, od_pend=in_odd_vld. A pair with both slot valids 0 is accepted and dropped.
- Simultaneous flush and load: the new pair loads; the old pair is discarded and nothing issues.
- stall_cycles: +1 each cycle with (ev_pend|od_pend) & ~ev_go & ~od_go & ~flush. Saturates at all-ones. Cleared only by reset.
- Reset mid-operation: all pending work is lost, and strobes drop asynchronously.

Test Plan:
- Reset, then pair even rt=5 ra=1 rb=2 and odd rt=6 ra=3 rb=4, all regstatus 0 -> dest_1=5, dest_2=6 in the same cycle; both strobes high next cycle; in_ready stays 1.
- regstatus_1_a=1 for 3 cycles on the same pair -> no issue for 3 cycles, stall_cycles=3, in_ready=0; both issue in cycle 4.
- Odd ra=5 equals even rt=5 -> cycle N: even issues, dest_2=0. Cycle N+1: odd waits while regstatus_2_a=1. Odd issues the first cycle regstatus_2_a=0.
- Even ra=0 and rb=0 with regstatus_1_a=1 forced, odd slot empty -> even issues immediately; no intra-pair check against rt=0.
- Even stalled, odd operands ready -> odd does not issue until even issues (in-order); dest_2 stays 0 meanwhile.
- Flush asserted while in BOTH with new in_valid -> no strobes next cycle; new pair held; stall_cycles unchanged. Assert reset mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/spu_issue_ctrl.sv
// Dual-issue dispatch stage: holds one decoded even/odd pair, checks operand
// readiness against the register scoreboard and issues each slot in order.
module spu_issue_ctrl #(
   parameter int ADDR_W = 7,
   parameter int OPC_W  = 11,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   // Upstream handshake: a pair transfers on a rising edge where in_valid and
   // in_ready are both 1; in_ready never depends on in_valid.
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_even_vld,
   input  logic              in_odd_vld,
   input  logic [OPC_W-1:0]  in_even_opc,
   input  logic [OPC_W-1:0]  in_odd_opc,
   input  logic [ADDR_W-1:0] in_even_ra,
   input  logic [ADDR_W-1:0] in_even_rb,
   input  logic [ADDR_W-1:0] in_even_rt,
   input  logic [ADDR_W-1:0] in_odd_ra,
   input  logic [ADDR_W-1:0] in_odd_rb,
   input  logic [ADDR_W-1:0] in_odd_rt,
   output logic [ADDR_W-1:0] ra_even_addr,
   output logic [ADDR_W-1:0] rb_even_addr,
   output logic [ADDR_W-1:0] ra_odd_addr,
   output logic [ADDR_W-1:0] rb_odd_addr,
   input  logic              regstatus_1_a,
   input  logic              regstatus_1_b,
   input  logic              regstatus_2_a,
   input  logic              regstatus_2_b,
   output logic [ADDR_W-1:0] dest_1,
   output logic [ADDR_W-1:0] dest_2,
   output logic              even_issue_vld,
   output logic              odd_issue_vld,
   output logic [OPC_W-1:0]  even_opc_o,
   output logic [ADDR_W-1:0] even_ra_o,
   output logic [ADDR_W-1:0] even_rb_o,
   output logic [ADDR_W-1:0] even_rt_o,
   output logic [OPC_W-1:0]  odd_opc_o,
   output logic [ADDR_W-1:0] odd_ra_o,
   output logic [ADDR_W-1:0] odd_rb_o,
   output logic [ADDR_W-1:0] odd_rt_o,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      EMPTY     = 2'b00,
      ODD_ONLY  = 2'b01,
      EVEN_ONLY = 2'b10,
      BOTH      = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic [OPC_W-1:0]  ev_opc_q, od_opc_q;
   logic [ADDR_W-1:0] ev_ra_q, ev_rb_q, ev_rt_q, od_ra_q, od_rb_q, od_rt_q;
   logic              ev_vld_q, od_vld_q;
   logic [OPC_W-1:0]  ev_opc_o_q, od_opc_o_q;
   logic [ADDR_W-1:0] ev_ra_o_q, ev_rb_o_q, ev_rt_o_q, od_ra_o_q, od_rb_o_q, od_rt_o_q;
   logic [CNT_W-1:0]  stall_q;

   logic ev_pend, od_pend, ev_busy, od_busy, raw_hit;
   logic ev_go, od_go, drained, load, stall_inc;

   assign ev_pend = state_q[1];
   assign od_pend = state_q[0];

   always_comb begin
      // Register 0 is hard-wired, so its busy bit is never a real hazard.
      ev_busy   = (regstatus_1_a && (ev_ra_q != '0)) || (regstatus_1_b && (ev_rb_q != '0));
      od_busy   = (regstatus_2_a && (od_ra_q != '0)) || (regstatus_2_b && (od_rb_q != '0));
      raw_hit   = (ev_rt_q != '0) && ((od_ra_q == ev_rt_q) || (od_rb_q == ev_rt_q));
      ev_go     = ev_pend && !ev_busy && !flush;
      od_go     = od_pend && !od_busy && !flush && (!ev_pend || ev_go) && !(ev_go && raw_hit);
      drained   = (!ev_pend || ev_go) && (!od_pend || od_go);
      in_ready  = drained || flush;
      load      = in_valid && in_ready;
      stall_inc = (ev_pend || od_pend) && !ev_go && !od_go && !flush;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         state_d = state_e'({ev_pend && !ev_go, od_pend && !od_go});
      end
      if (load) begin
         state_d = state_e'({in_even_vld, in_odd_vld});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_opc_q <= '0; ev_ra_q <= '0; ev_rb_q <= '0; ev_rt_q <= '0;
         od_opc_q <= '0; od_ra_q <= '0; od_rb_q <= '0; od_rt_q <= '0;
      end else if (load) begin
         ev_opc_q <= in_even_opc; ev_ra_q <= in_even_ra; ev_rb_q <= in_even_rb; ev_rt_q <= in_even_rt;
         od_opc_q <= in_odd_opc;  od_ra_q <= in_odd_ra;  od_rb_q <= in_odd_rb;  od_rt_q <= in_odd_rt;
      end
   end

   // Issued fields are zeroed on idle cycles so they only carry data with the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_vld_q <= 1'b0; od_vld_q <= 1'b0;
         ev_opc_o_q <= '0; ev_ra_o_q <= '0; ev_rb_o_q <= '0; ev_rt_o_q <= '0;
         od_opc_o_q <= '0; od_ra_o_q <= '0; od_rb_o_q <= '0; od_rt_o_q <= '0;
         stall_q <= '0;
      end else begin
         ev_vld_q   <= ev_go;
         od_vld_q   <= od_go;
         ev_opc_o_q <= ev_go ? ev_opc_q : '0;
         ev_ra_o_q  <= ev_go ? ev_ra_q  : '0;
         ev_rb_o_q  <= ev_go ? ev_rb_q  : '0;
         ev_rt_o_q  <= ev_go ? ev_rt_q  : '0;
         od_opc_o_q <= od_go ? od_opc_q : '0;
         od_ra_o_q  <= od_go ? od_ra_q  : '0;
         od_rb_o_q  <= od_go ? od_rb_q  : '0;
         od_rt_o_q  <= od_go ? od_rt_q  : '0;
         if (stall_inc && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
         end
      end
   end

   assign ra_even_addr   = ev_ra_q;
   assign rb_even_addr   = ev_rb_q;
   assign ra_odd_addr    = od_ra_q;
   assign rb_odd_addr    = od_rb_q;
   assign dest_1         = ev_go ? ev_rt_q : '0;
   assign dest_2         = od_go ? od_rt_q : '0;
   assign even_issue_vld = ev_vld_q;
   assign odd_issue_vld  = od_vld_q;
   assign even_opc_o     = ev_opc_o_q;
   assign even_ra_o      = ev_ra_o_q;
   assign even_rb_o      = ev_rb_o_q;
   assign even_rt_o      = ev_rt_o_q;
   assign odd_opc_o      = od_opc_o_q;
   assign odd_ra_o       = od_ra_o_q;
   assign odd_rb_o       = od_rb_o_q;
   assign odd_rt_o       = od_rt_o_q;
   assign stall_cycles   = stall_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Bench for spu_issue_ctrl: directed hazard/flush/reset scenarios followed by
// random pairs under random scoreboard busy bits, checked via per-slot queues.
module tb_spu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, in_ready;
   logic        in_even_vld, in_odd_vld;
   logic [10:0] in_even_opc, in_odd_opc;
   logic [6:0]  in_even_ra, in_even_rb, in_even_rt, in_odd_ra, in_odd_rb, in_odd_rt;
   logic [6:0]  ra_even_addr, rb_even_addr, ra_odd_addr, rb_odd_addr;
   logic        rs1a, rs1b, rs2a, rs2b;
   logic [6:0]  dest_1, dest_2;
   logic        even_issue_vld, odd_issue_vld;
   logic [10:0] even_opc_o, odd_opc_o;
   logic [6:0]  even_ra_o, even_rb_o, even_rt_o, odd_ra_o, odd_rb_o, odd_rt_o;
   logic [15:0] stall_cycles;
   logic [1:0]  state_dbg;

   logic [31:0] exp_ev_q[$];
   logic [31:0] exp_od_q[$];
   int n_chk = 0;
   int n_fail = 0;

   spu_issue_ctrl dut (
      .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_even_vld(in_even_vld), .in_odd_vld(in_odd_vld),
      .in_even_opc(in_even_opc), .in_odd_opc(in_odd_opc),
      .in_even_ra(in_even_ra), .in_even_rb(in_even_rb), .in_even_rt(in_even_rt),
      .in_odd_ra(in_odd_ra), .in_odd_rb(in_odd_rb), .in_odd_rt(in_odd_rt),
      .ra_even_addr(ra_even_addr), .rb_even_addr(rb_even_addr),
      .ra_odd_addr(ra_odd_addr), .rb_odd_addr(rb_odd_addr),
      .regstatus_1_a(rs1a), .regstatus_1_b(rs1b), .regstatus_2_a(rs2a), .regstatus_2_b(rs2b),
      .dest_1(dest_1), .dest_2(dest_2),
      .even_issue_vld(even_issue_vld), .odd_issue_vld(odd_issue_vld),
      .even_opc_o(even_opc_o), .even_ra_o(even_ra_o), .even_rb_o(even_rb_o), .even_rt_o(even_rt_o),
      .odd_opc_o(odd_opc_o), .odd_ra_o(odd_ra_o), .odd_rb_o(odd_rb_o), .odd_rt_o(odd_rt_o),
      .stall_cycles(stall_cycles), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // driver tasks
   task automatic set_pair(input logic ev, input logic [10:0] eo, input logic [6:0] ea, eb, et,
                           input logic od, input logic [10:0] oo, input logic [6:0] oa, ob, ot);
      in_even_vld = ev; in_even_opc = eo; in_even_ra = ea; in_even_rb = eb; in_even_rt = et;
      in_odd_vld  = od; in_odd_opc  = oo; in_odd_ra  = oa; in_odd_rb  = ob; in_odd_rt  = ot;
      in_valid = 1'b1;
   endtask

   task automatic push_pair();
      if (in_even_vld) exp_ev_q.push_back({in_even_opc, in_even_ra, in_even_rb, in_even_rt});
      if (in_odd_vld)  exp_od_q.push_back({in_odd_opc, in_odd_ra, in_odd_rb, in_odd_rt});
   endtask

   task automatic rand_pair();
      logic acc;
      acc = 1'b0;
      set_pair(1'($urandom_range(0, 1)), 11'($urandom), 7'($urandom_range(0, 12)),
               7'($urandom_range(0, 12)), 7'($urandom_range(0, 12)),
               1'($urandom_range(0, 1)), 11'($urandom), 7'($urandom_range(0, 12)),
               7'($urandom_range(0, 12)), 7'($urandom_range(0, 12)));
      for (int c = 0; c < 100 && !acc; c++) begin
         rs1a = ($urandom_range(0, 3) == 0); rs1b = ($urandom_range(0, 3) == 0);
         rs2a = ($urandom_range(0, 3) == 0); rs2b = ($urandom_range(0, 3) == 0);
         neg();
         if (in_ready) begin
            acc = 1'b1;
            push_pair();
         end
         tick();
      end
      in_valid = 1'b0;
      chk("rand_accept", 32'(acc), 32'd1);
   endtask

   // scoreboard: every issue strobe must match the oldest expected record of its slot
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (even_issue_vld) begin
            if (exp_ev_q.size() == 0) chk("even_unexpected", 32'd1, 32'd0);
            else chk("even_issue", {even_opc_o, even_ra_o, even_rb_o, even_rt_o}, exp_ev_q.pop_front());
         end
         if (odd_issue_vld) begin
            if (exp_od_q.size() == 0) chk("odd_unexpected", 32'd1, 32'd0);
            else chk("odd_issue", {odd_opc_o, odd_ra_o, odd_rb_o, odd_rt_o}, exp_od_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      rs1a = 1'b0; rs1b = 1'b0; rs2a = 1'b0; rs2b = 1'b0;
      set_pair(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      #12;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_dest", {18'd0, dest_1, dest_2}, 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      tick();
      rst = 1'b0;

      // basic dual issue
      set_pair(1, 11'h101, 7'd1, 7'd2, 7'd5, 1, 11'h102, 7'd3, 7'd4, 7'd6); push_pair();
      neg(); chk("t1_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      neg(); chk("t1_dest", {18'd0, dest_1, dest_2}, {18'd0, 7'd5, 7'd6});
      chk("t1_ready_held", 32'(in_ready), 32'd1);
      tick();
      neg(); chk("t1_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd3);

      // even operand busy for 3 cycles
      tick();
      set_pair(1, 11'h201, 7'd8, 7'd9, 7'd7, 1, 11'h202, 7'd11, 7'd12, 7'd10); push_pair();
      rs1a = 1'b1;
      neg(); chk("t2_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("t2_ready_stall", 32'(in_ready), 32'd0);
         chk("t2_dest_stall", {18'd0, dest_1, dest_2}, 32'd0);
         chk("t2_state", 32'(state_dbg), 32'd3);
         tick();
         chk("t2_stall_cnt", 32'(stall_cycles), 32'(i + 1));
         chk("t2_no_strobe", {30'd0, even_issue_vld, odd_issue_vld}, 32'd0);
      end
      rs1a = 1'b0;
      neg(); chk("t2_dest_go", {18'd0, dest_1, dest_2}, {18'd0, 7'd7, 7'd10});
      chk("t2_ready_go", 32'(in_ready), 32'd1);
      tick(); chk("t2_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd3);

      // intra-pair RAW then scoreboard busy
      set_pair(1, 11'h301, 7'd13, 7'd14, 7'd5, 1, 11'h302, 7'd5, 7'd16, 7'd15); push_pair();
      neg(); chk("t3_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      neg(); chk("t3_dest_raw", {18'd0, dest_1, dest_2}, {18'd0, 7'd5, 7'd0});
      chk("t3_ready_raw", 32'(in_ready), 32'd0);
      tick(); rs2a = 1'b1;
      chk("t3_even_only", {30'd0, even_issue_vld, odd_issue_vld}, 32'd2);
      neg(); chk("t3_dest2_busy", 32'(dest_2), 32'd0);
      chk("t3_ready_busy", 32'(in_ready), 32'd0);
      tick();
      neg(); chk("t3_dest2_busy2", 32'(dest_2), 32'd0);
      tick(); rs2a = 1'b0;
      neg(); chk("t3_dest2_go", 32'(dest_2), 32'd15);
      chk("t3_ready_go", 32'(in_ready), 32'd1);
      chk("t3_stall_cnt", 32'(stall_cycles), 32'd5);
      tick(); chk("t3_odd_only", {30'd0, even_issue_vld, odd_issue_vld}, 32'd1);

      // zero sources ignore busy bits; odd slot empty
      set_pair(1, 11'h401, 7'd0, 7'd0, 7'd20, 0, 11'h0, 7'd0, 7'd0, 7'd0); push_pair();
      rs1a = 1'b1; rs1b = 1'b1;
      neg(); chk("t4_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      neg(); chk("t4_dest", {18'd0, dest_1, dest_2}, {18'd0, 7'd20, 7'd0});
      chk("t4_ready", 32'(in_ready), 32'd1);
      tick(); chk("t4_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd2);
      rs1a = 1'b0; rs1b = 1'b0;

      // even rt=0 never creates a RAW against odd source 0
      set_pair(1, 11'h402, 7'd22, 7'd23, 7'd0, 1, 11'h403, 7'd0, 7'd0, 7'd21); push_pair();
      neg(); chk("t4b_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      neg(); chk("t4b_dest", {18'd0, dest_1, dest_2}, {18'd0, 7'd0, 7'd21});
      tick(); chk("t4b_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd3);

      // in-order: odd ready but even stalled
      set_pair(1, 11'h501, 7'd24, 7'd25, 7'd26, 1, 11'h502, 7'd27, 7'd28, 7'd29); push_pair();
      rs1b = 1'b1;
      neg(); chk("t5_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         neg();
         chk("t5_dest_hold", {18'd0, dest_1, dest_2}, 32'd0);
         chk("t5_ready_hold", 32'(in_ready), 32'd0);
         tick();
         chk("t5_no_strobe", {30'd0, even_issue_vld, odd_issue_vld}, 32'd0);
      end
      rs1b = 1'b0;
      neg(); chk("t5_dest_go", {18'd0, dest_1, dest_2}, {18'd0, 7'd26, 7'd29});
      tick(); chk("t5_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd3);
      chk("t5_stall_cnt", 32'(stall_cycles), 32'd7);

      // flush with simultaneous load, then reset mid-stall
      set_pair(1, 11'h601, 7'd51, 7'd52, 7'd50, 1, 11'h602, 7'd54, 7'd55, 7'd53);
      rs1a = 1'b1;
      neg(); chk("t6_ready_empty", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      neg(); chk("t6_ready_stall", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b1;
      set_pair(1, 11'h603, 7'd31, 7'd32, 7'd30, 1, 11'h604, 7'd34, 7'd35, 7'd33); push_pair();
      neg(); chk("t6_ready_flush", 32'(in_ready), 32'd1);
      chk("t6_dest_flush", {18'd0, dest_1, dest_2}, 32'd0);
      tick(); flush = 1'b0; in_valid = 1'b0;
      chk("t6_no_strobe", {30'd0, even_issue_vld, odd_issue_vld}, 32'd0);
      chk("t6_stall_cnt", 32'(stall_cycles), 32'd8);
      neg(); chk("t6_new_held", 32'(state_dbg), 32'd3);
      chk("t6_ready_new", 32'(in_ready), 32'd0);
      tick(); rs1a = 1'b0;
      set_pair(1, 11'h605, 7'd40, 7'd41, 7'd42, 1, 11'h606, 7'd43, 7'd44, 7'd45);
      neg(); chk("t6_dest_new", {18'd0, dest_1, dest_2}, {18'd0, 7'd30, 7'd33});
      tick(); in_valid = 1'b0; rs1a = 1'b1;
      chk("t6_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("t7_strobes", {30'd0, even_issue_vld, odd_issue_vld}, 32'd0);
      chk("t7_fields", {4'd0, even_rt_o, odd_rt_o, odd_opc_o}, 32'd0);
      chk("t7_stall", 32'(stall_cycles), 32'd0);
      chk("t7_dest", {18'd0, dest_1, dest_2}, 32'd0);
      chk("t7_ready", 32'(in_ready), 32'd1);
      chk("t7_state", 32'(state_dbg), 32'd0);
      tick(); rst = 1'b0; rs1a = 1'b0;

      // random pairs under random busy bits
      for (int p = 0; p < 60; p++) rand_pair();
      rs1a = 1'b0; rs1b = 1'b0; rs2a = 1'b0; rs2b = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("drain_even_q", 32'(exp_ev_q.size()), 32'd0);
      chk("drain_odd_q", 32'(exp_od_q.size()), 32'd0);
      chk("drain_ready", 32'(in_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
